// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: lap RAM operation codes, lap_recorder states and the shared ring-wrap helper.
package stopwatch_pkg;
    localparam logic [1:0] MEM_OP_IDLE  = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CLR_WR,
        S_CLR_GAP,
        S_GAP
    } lr_state_t;

    // Successor in the 1..limit ring; an index of 0 (nothing selected) steps to 1.
    function automatic int unsigned ring_next(input int unsigned idx, input int unsigned limit);
        return (idx >= limit) ? 32'd1 : idx + 32'd1;
    endfunction
endpackage

// File: rtl/ring_index.sv
// ring_index: 1..limit wrapping counter with runtime limit; clear and reset load CLR_ONE (1 or 0).
module ring_index
    import stopwatch_pkg::*;
#(
    parameter int W       = 3,
    parameter bit CLR_ONE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_limit,
    input  logic         i_adv,
    input  logic         i_clr,
    output logic [W-1:0] o_idx
);
    logic [W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idx <= W'(CLR_ONE);
        else if (i_clr)
            r_idx <= W'(CLR_ONE);
        else if (i_adv)
            r_idx <= W'(ring_next(32'(r_idx), 32'(i_limit)));
    end

    assign o_idx = r_idx;
endmodule

// File: rtl/lap_recorder.sv
// lap_recorder: records lap times into the lap RAM, browses stored laps and clears the RAM,
// pacing every RAM access as one operation cycle followed by one idle cycle.
module lap_recorder
    import stopwatch_pkg::*;
#(
    parameter int MEM_SIZE = 5,
    parameter int IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      time_in,
    input  logic             lap_req,
    input  logic             next_req,
    input  logic             clear_req,
    output logic [1:0]       mem_op,
    output logic [31:0]      mem_offset,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      view_data,
    output logic [IDX_W-1:0] view_index,
    output logic [IDX_W-1:0] lap_count,
    output logic             busy
);
    lr_state_t        r_state, w_state_nxt;
    logic [31:0]      r_offset, r_wdata, r_view_data;
    logic [IDX_W-1:0] r_lap_count, w_wr_ptr, w_view_index, w_view_next;
    logic             w_acc_clr, w_acc_lap, w_acc_next, w_clr_done;

    ring_index #(.W(IDX_W), .CLR_ONE(1'b1)) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_limit (IDX_W'(MEM_SIZE)),
        .i_adv   (r_state == S_WRITE),
        .i_clr   (w_clr_done),
        .o_idx   (w_wr_ptr)
    );

    ring_index #(.W(IDX_W), .CLR_ONE(1'b0)) u_view_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_limit (r_lap_count),
        .i_adv   (r_state == S_READ),
        .i_clr   (w_clr_done),
        .o_idx   (w_view_index)
    );

    assign w_view_next = IDX_W'(ring_next(32'(w_view_index), 32'(r_lap_count)));

    always_comb begin
        w_acc_clr   = (r_state == S_IDLE) && clear_req;
        w_acc_lap   = (r_state == S_IDLE) && !clear_req && lap_req;
        w_acc_next  = (r_state == S_IDLE) && !clear_req && !lap_req && next_req && (r_lap_count != '0);
        w_clr_done  = (r_state == S_CLR_GAP) && (r_offset == 32'(MEM_SIZE));
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:          w_state_nxt = w_acc_clr ? S_CLR_WR : w_acc_lap ? S_WRITE : w_acc_next ? S_READ : S_IDLE;
            S_WRITE, S_READ: w_state_nxt = S_GAP;
            S_CLR_WR:        w_state_nxt = S_CLR_GAP;
            S_CLR_GAP:       w_state_nxt = w_clr_done ? S_IDLE : S_CLR_WR;
            default:         w_state_nxt = S_IDLE;
        endcase
        mem_op = (r_state == S_WRITE || r_state == S_CLR_WR) ? MEM_OP_WRITE :
                 (r_state == S_READ) ? MEM_OP_READ : MEM_OP_IDLE;
        busy   = r_state != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Offset doubles as the clear sweep position, so it walks 1..MEM_SIZE during a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset    <= '0;
            r_wdata     <= '0;
            r_view_data <= '0;
            r_lap_count <= '0;
        end else begin
            if (w_acc_clr) begin
                r_offset <= 32'd1;
                r_wdata  <= '0;
            end
            if (w_acc_lap) begin
                r_offset <= 32'(w_wr_ptr);
                r_wdata  <= time_in;
            end
            if (w_acc_next)
                r_offset <= 32'(w_view_next);
            if (r_state == S_WRITE && r_lap_count != IDX_W'(MEM_SIZE))
                r_lap_count <= r_lap_count + IDX_W'(1);
            if (r_state == S_READ)
                r_view_data <= mem_rdata;
            if (r_state == S_CLR_GAP && !w_clr_done)
                r_offset <= r_offset + 32'd1;
            if (w_clr_done) begin
                r_lap_count <= '0;
                r_view_data <= '0;
            end
        end
    end

    assign mem_offset = r_offset;
    assign mem_wdata  = r_wdata;
    assign view_data  = r_view_data;
    assign view_index = w_view_index;
    assign lap_count  = r_lap_count;
endmodule

// File: tb/tb_lap_recorder.sv
// tb_lap_recorder: directed bench for lap_recorder with a behavioural lap RAM.
module tb_lap_recorder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] time_in = '0;
    logic        lap_req = 1'b0;
    logic        next_req = 1'b0;
    logic        clear_req = 1'b0;
    logic [1:0]  mem_op;
    logic [31:0] mem_offset, mem_wdata, mem_rdata, view_data;
    logic [2:0]  view_index, lap_count;
    logic        busy;
    logic [31:0] ram [0:7];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          wr_base;

    always #5 clk = ~clk;

    lap_recorder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_in    (time_in),
        .lap_req    (lap_req),
        .next_req   (next_req),
        .clear_req  (clear_req),
        .mem_op     (mem_op),
        .mem_offset (mem_offset),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .view_data  (view_data),
        .view_index (view_index),
        .lap_count  (lap_count),
        .busy       (busy)
    );

    assign mem_rdata = ram[mem_offset[2:0]];

    always @(posedge clk) begin
        if (mem_op == 2'b10) begin
            ram[mem_offset[2:0]] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses the requests for exactly one sampling edge; returns 1 time unit after that edge.
    task automatic req(input logic l, input logic n, input logic c, input logic [31:0] t);
        @(posedge clk);
        #1;
        time_in = t; lap_req = l; next_req = n; clear_req = c;
        @(posedge clk);
        #1;
        lap_req = 1'b0; next_req = 1'b0; clear_req = 1'b0;
    endtask

    task automatic do_lap(input logic [31:0] t, input logic [31:0] off);
        req(1'b1, 1'b0, 1'b0, t);
        chk("lap_op", 32'(mem_op), 32'd2);
        chk("lap_off", mem_offset, off);
        chk("lap_data", mem_wdata, t);
        chk("lap_busy", 32'(busy), 32'd1);
        step();
        chk("lap_gap_op", 32'(mem_op), 32'd0);
        step();
        chk("lap_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_next(input logic [2:0] idx, input logic [31:0] d);
        req(1'b0, 1'b1, 1'b0, 32'd0);
        chk("nx_op", 32'(mem_op), 32'd1);
        chk("nx_off", mem_offset, 32'(idx));
        step();
        chk("nx_idx", 32'(view_index), 32'(idx));
        chk("nx_data", view_data, d);
        chk("nx_gap_op", 32'(mem_op), 32'd0);
        step();
    endtask

    initial begin
        step(3);
        chk("rst_op", 32'(mem_op), 32'd0);
        chk("rst_off", mem_offset, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_vdata", view_data, 32'd0);
        chk("rst_vidx", 32'(view_index), 32'd0);
        chk("rst_cnt", 32'(lap_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        do_lap(32'd100, 32'd1);
        step(2);
        do_lap(32'd200, 32'd2);
        step(2);
        do_lap(32'd300, 32'd3);
        chk("laps_cnt", 32'(lap_count), 32'd3);
        chk("ram1", ram[1], 32'd100);
        chk("ram2", ram[2], 32'd200);
        chk("ram3", ram[3], 32'd300);

        do_next(3'd1, 32'd100);
        do_next(3'd2, 32'd200);
        do_next(3'd3, 32'd300);
        do_next(3'd1, 32'd100);

        wr_base = n_wr;
        req(1'b1, 1'b0, 1'b0, 32'd400);
        chk("drop_off", mem_offset, 32'd4);
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        step(3);
        chk("drop_cnt", 32'(lap_count), 32'd4);
        chk("drop_nwr", 32'(n_wr - wr_base), 32'd1);
        chk("browse_vidx", 32'(view_index), 32'd1);
        chk("browse_vdata", view_data, 32'd100);

        req(1'b1, 1'b0, 1'b1, 32'd500);
        chk("prio_wdata", mem_wdata, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            chk("clr_op", 32'(mem_op), 32'd2);
            chk("clr_off", mem_offset, 32'(k));
            chk("clr_busy", 32'(busy), 32'd1);
            step();
            chk("clr_gap_op", 32'(mem_op), 32'd0);
            chk("clr_gap_busy", 32'(busy), 32'd1);
            step();
        end
        chk("clr_done_busy", 32'(busy), 32'd0);
        chk("clr_cnt", 32'(lap_count), 32'd0);
        chk("clr_vidx", 32'(view_index), 32'd0);
        chk("clr_vdata", view_data, 32'd0);
        chk("clr_ram1", ram[1], 32'd0);
        chk("clr_ram4", ram[4], 32'd0);

        req(1'b0, 1'b1, 1'b0, 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_op", 32'(mem_op), 32'd0);
        chk("empty_vidx", 32'(view_index), 32'd0);

        for (int i = 1; i <= 7; i++)
            do_lap(32'(i), 32'(((i - 1) % 5) + 1));
        chk("wrap_cnt", 32'(lap_count), 32'd5);
        chk("wrap_ram1", ram[1], 32'd6);
        chk("wrap_ram2", ram[2], 32'd7);
        chk("wrap_ram3", ram[3], 32'd3);
        chk("wrap_ram4", ram[4], 32'd4);
        chk("wrap_ram5", ram[5], 32'd5);
        do_lap(32'd8, 32'd3);
        chk("wrap_sat_cnt", 32'(lap_count), 32'd5);

        req(1'b0, 1'b0, 1'b1, 32'd0);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("mrst_op", 32'(mem_op), 32'd0);
        chk("mrst_off", mem_offset, 32'd0);
        chk("mrst_wdata", mem_wdata, 32'd0);
        chk("mrst_vdata", view_data, 32'd0);
        chk("mrst_vidx", 32'(view_index), 32'd0);
        chk("mrst_cnt", 32'(lap_count), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        do_lap(32'd42, 32'd1);
        chk("mrst_ram3_kept", ram[3], 32'd8);
        chk("mrst_cnt1", 32'(lap_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
